// File: rtl/ah_snoop_initiator_if.sv
// Request, snoop and grant signals of the snoop initiator.
// master: the initiator itself; slave: upstream source, snoopable FIFO and downstream consumer.
interface ah_snoop_initiator_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] req_data;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] sdata;
  logic              svalid;
  logic              smatch;
  logic [DATA_W-1:0] gnt_data;
  logic              gnt_valid;
  logic              gnt_err;
  logic              gnt_ready;

  modport master (
    input  req_data, req_valid, smatch, gnt_ready,
    output req_ready, sdata, svalid, gnt_data, gnt_valid, gnt_err
  );

  modport slave (
    output req_data, req_valid, smatch, gnt_ready,
    input  req_ready, sdata, svalid, gnt_data, gnt_valid, gnt_err
  );
endinterface

// File: rtl/ah_snoop_initiator.sv
// Snoop initiator: holds one request, snoops the FIFO until clear (or retry limit), then grants it.
// Optional hit/forced-grant counters are enabled by defining AH_SNOOP_INIT_STATS_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | req_ready=1, waiting for an upstream request
// S_SNOOP   | svalid=1 for one cycle with the held word
// S_WAIT    | waiting SNOOP_LAT cycles for the smatch sample
// S_BACKOFF | idle BACKOFF_CYC cycles after a match, then re-snoop
// S_ISSUE   | gnt_valid=1 until gnt_ready
module ah_snoop_initiator #(
  parameter int DATA_W      = 64,
  parameter int SNOOP_LAT   = 0,
  parameter int BACKOFF_CYC = 4,
  parameter int MAX_RETRY   = 7
) (
  input  logic                 clk,
  input  logic                 rstn,
  ah_snoop_initiator_if.master bus
`ifdef AH_SNOOP_INIT_STATS_EN
  ,
  output logic [15:0]          stat_hits,
  output logic [15:0]          stat_forced
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SNOOP   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_BACKOFF = 3'd3;
  localparam logic [2:0] S_ISSUE   = 3'd4;

  localparam int RW = (MAX_RETRY   < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int BW = (BACKOFF_CYC < 1) ? 1 : $clog2(BACKOFF_CYC + 1);

  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [BW-1:0] BO_LOAD   = BW'(BACKOFF_CYC - 1);
  localparam logic [1:0]    WAIT_LOAD = (SNOOP_LAT > 0) ? 2'(SNOOP_LAT - 1) : 2'd0;

  logic [2:0]        state_q;
  logic [DATA_W-1:0] sdata_q;
  logic [DATA_W-1:0] gnt_data_q;
  logic              req_ready_q;
  logic              svalid_q;
  logic              gnt_valid_q;
  logic              gnt_err_q;
  logic [RW-1:0]     retry_q;
  logic [BW-1:0]     bo_q;
  logic [1:0]        wait_q;
  logic              sample_now;
  logic              retry_full;

  // smatch only matters in the single cycle SNOOP_LAT cycles after the svalid cycle
  always_comb begin
    sample_now = 1'b0;
    if (state_q == S_SNOOP && SNOOP_LAT == 0) sample_now = 1'b1;
    if (state_q == S_WAIT && wait_q == 2'd0)  sample_now = 1'b1;
  end

  assign retry_full = (retry_q == RETRY_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      sdata_q     <= '0;
      gnt_data_q  <= '0;
      req_ready_q <= 1'b1;
      svalid_q    <= 1'b0;
      gnt_valid_q <= 1'b0;
      gnt_err_q   <= 1'b0;
      retry_q     <= '0;
      bo_q        <= '0;
      wait_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            sdata_q     <= bus.req_data;
            retry_q     <= '0;
            svalid_q    <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= S_SNOOP;
          end
        end
        S_SNOOP: begin
          svalid_q <= 1'b0;
          if (SNOOP_LAT != 0) begin
            wait_q  <= WAIT_LOAD;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_q != 2'd0) wait_q <= wait_q - 2'd1;
        end
        S_BACKOFF: begin
          if (bo_q == '0) begin
            svalid_q <= 1'b1;
            state_q  <= S_SNOOP;
          end else begin
            bo_q <= bo_q - BW'(1);
          end
        end
        S_ISSUE: begin
          if (bus.gnt_ready) begin
            gnt_valid_q <= 1'b0;
            gnt_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          svalid_q    <= 1'b0;
          gnt_valid_q <= 1'b0;
          gnt_err_q   <= 1'b0;
        end
      endcase

      // Result resolution overrides the SNOOP/WAIT next-state chosen above
      if (sample_now) begin
        if (!bus.smatch) begin
          gnt_valid_q <= 1'b1;
          gnt_data_q  <= sdata_q;
          gnt_err_q   <= 1'b0;
          state_q     <= S_ISSUE;
        end else if (!retry_full) begin
          retry_q <= retry_q + RW'(1);
          bo_q    <= BO_LOAD;
          state_q <= S_BACKOFF;
        end else begin
          gnt_valid_q <= 1'b1;
          gnt_data_q  <= sdata_q;
          gnt_err_q   <= 1'b1;
          state_q     <= S_ISSUE;
        end
      end
    end
  end

`ifdef AH_SNOOP_INIT_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_hits   <= '0;
      stat_forced <= '0;
    end else begin
      if (sample_now && bus.smatch && stat_hits != 16'hFFFF)
        stat_hits <= stat_hits + 16'd1;
      if (sample_now && bus.smatch && retry_full && stat_forced != 16'hFFFF)
        stat_forced <= stat_forced + 16'd1;
    end
  end
`endif

  assign bus.req_ready = req_ready_q;
  assign bus.sdata     = sdata_q;
  assign bus.svalid    = svalid_q;
  assign bus.gnt_data  = gnt_data_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_err   = gnt_err_q;

endmodule
